vga_frame_reader: RTL and testbench

Display-side reader of the 80×60 video frame buffer that the CPU fills with `VGA` instructions. Generates 640×480@60 Hz VGA timing from the 50 MHz system clock, fetches one 3-bit colour cell per 8×8 pixel block from the frame-buffer RAM read port, and drives the VGA sync and RGB pins. It sits between the frame-buffer RAM's read port and the board's VGA connector, opposite the CPU write path.

---
 rtl/vga_frame_reader_pkg.sv | 40 ++++
 rtl/vga_frame_reader_timing_counter.sv | 76 +++++++
 rtl/vga_frame_reader.sv | 91 +++++++++
 tb/tb_vga_frame_reader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/vga_frame_reader_pkg.sv
// Shared types, widths and helpers for the VGA frame-buffer reader.
// Colour bit positions match the COLOR_* cell encoding written by the CPU.
package vga_frame_reader_pkg;

   localparam int CNT_W   = 10;
   localparam int ADDR_W  = 13;
   localparam int COL_W   = 7;
   localparam int ROW_W   = 6;
   localparam int COLOR_W = 3;

   localparam int COLOR_R_BIT = 2;
   localparam int COLOR_G_BIT = 1;
   localparam int COLOR_B_BIT = 0;

   typedef logic [CNT_W-1:0]   cnt_t;
   typedef logic [COLOR_W-1:0] color_t;

   // Everything the output stage needs about the current counter position.
   typedef struct packed {
      cnt_t h;
      cnt_t v;
      logic visible;
      logic hs_n;
      logic vs_n;
      logic vblank;
      logic wrap;
   } vga_timing_t;

   // Cell index row*fb_w + col; the col/row truncation keeps blanking positions below 8192.
   function automatic logic [ADDR_W-1:0] cell_addr(input cnt_t h, input cnt_t v,
                                                   input int unsigned shift,
                                                   input int unsigned fb_w);
      logic [COL_W-1:0] col;
      logic [ROW_W-1:0] row;
      col = COL_W'(h >> shift);
      row = ROW_W'(v >> shift);
      return ADDR_W'(row) * ADDR_W'(fb_w) + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/vga_frame_reader_timing_counter.sv
// Pixel-enable divider plus horizontal/vertical raster counters.
// Produces raw (unregistered) visible, sync and wrap flags for the current position.
module vga_timing_counter
   import vga_frame_reader_pkg::*;
#(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        pix_en_o,
   output vga_timing_t timing_o
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
   localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
   localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
   localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
   localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

   logic pix_en_q, pix_en_d;
   cnt_t h_q, h_d;
   cnt_t v_q, v_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pix_en_q <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
      end else begin
         pix_en_q <= pix_en_d;
         h_q      <= h_d;
         v_q      <= v_d;
      end
   end

   always_comb begin
      pix_en_d = ~pix_en_q;
      h_d      = h_q;
      v_d      = v_q;
      if (pix_en_q) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
         end else begin
            h_d = h_q + cnt_t'(1);
         end
      end
   end

   always_comb begin
      timing_o         = '0;
      timing_o.h       = h_q;
      timing_o.v       = v_q;
      timing_o.visible = (h_q < H_VIS) && (v_q < V_VIS);
      timing_o.hs_n    = !((h_q >= HS_START) && (h_q < HS_END));
      timing_o.vs_n    = !((v_q >= VS_START) && (v_q < VS_END));
      timing_o.vblank  = (v_q >= V_VIS);
      timing_o.wrap    = pix_en_q && (h_q == H_LAST) && (v_q == V_LAST);
   end

   assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_frame_reader.sv
// Reads 8x8-pixel colour cells from the frame-buffer RAM and drives VGA pins.
// Outputs lag the counters by one pixel so the RAM's one-Clock read latency lines up.
module vga_frame_reader
   import vga_frame_reader_pkg::*;
#(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int CELL_SHIFT = 3,
   parameter int FB_WIDTH   = 80
) (
   input  logic              Clock,
   input  logic              Reset,
   output logic [ADDR_W-1:0] oReadAddress,
   input  logic [COLOR_W-1:0] iReadData,
   output logic              oVGA_R,
   output logic              oVGA_G,
   output logic              oVGA_B,
   output logic              oVGA_HS,
   output logic              oVGA_VS,
   output logic              oVBlank,
   output logic              oFrameStart
);

   logic        pix_en;
   vga_timing_t tm;

   vga_timing_counter #(
      .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
      .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
   ) u_timing (
      .clk_i    (Clock),
      .rst_i    (Reset),
      .pix_en_o (pix_en),
      .timing_o (tm)
   );

   assign oReadAddress = cell_addr(tm.h, tm.v, CELL_SHIFT, FB_WIDTH);

   color_t rgb_q, rgb_d;
   logic   hs_q, hs_d;
   logic   vs_q, vs_d;
   logic   vblank_q, vblank_d;
   logic   fs_q, fs_d;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rgb_q    <= '0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         vblank_q <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         rgb_q    <= rgb_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         vblank_q <= vblank_d;
         fs_q     <= fs_d;
      end
   end

   // iReadData here belongs to the address presented one Clock earlier, i.e. the same position.
   always_comb begin
      rgb_d    = rgb_q;
      hs_d     = hs_q;
      vs_d     = vs_q;
      vblank_d = vblank_q;
      fs_d     = 1'b0;
      if (pix_en) begin
         rgb_d    = tm.visible ? iReadData : '0;
         hs_d     = tm.hs_n;
         vs_d     = tm.vs_n;
         vblank_d = tm.vblank;
         fs_d     = tm.wrap;
      end
   end

   assign oVGA_R      = rgb_q[COLOR_R_BIT];
   assign oVGA_G      = rgb_q[COLOR_G_BIT];
   assign oVGA_B      = rgb_q[COLOR_B_BIT];
   assign oVGA_HS     = hs_q;
   assign oVGA_VS     = vs_q;
   assign oVBlank     = vblank_q;
   assign oFrameStart = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomised frame-buffer contents checked against an arithmetic raster model.
// Uses a shrunken raster so several whole frames fit in a short run.
module tb_vga_frame_reader;

   localparam int HV = 64, HF = 8, HSW = 16, HB = 8;
   localparam int VV = 24, VF = 3, VSW = 2, VB = 4;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] addr;
   logic [2:0]  rdata = 3'b000;
   logic        r, g, b, hs, vs, vb, fs;

   always #10 clk = ~clk;

   vga_frame_reader #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
      .CELL_SHIFT(3), .FB_WIDTH(80)
   ) dut (
      .Clock(clk), .Reset(rst), .oReadAddress(addr), .iReadData(rdata),
      .oVGA_R(r), .oVGA_G(g), .oVGA_B(b), .oVGA_HS(hs), .oVGA_VS(vs),
      .oVBlank(vb), .oFrameStart(fs)
   );

   logic [2:0] mem [0:8191];
   logic       force7 = 1'b0;

   always @(posedge clk) rdata <= force7 ? 3'b111 : mem[addr];

   int vectors = 0, miscompares = 0;
   int t = 0;
   bit force_smp = 0, force_out = 0;
   int hs_low_len = 0, vs_low_len = 0, last_fs = 0;
   bit fs_seen = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   function automatic int model_addr(input int h, input int v);
      return (v / 8) * 80 + (h / 8);
   endfunction

   task automatic check();
      int a, p, h, v, h2, v2;
      bit vis;
      logic [2:0] e_rgb;
      logic e_hs, e_vs, e_vb, e_fs;
      a = t / 2;
      if (a == 0) begin
         e_rgb = 3'b000; e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0;
      end else begin
         p = a - 1;
         h = p % HT;
         v = (p / HT) % VT;
         vis = (h < HV) && (v < VV);
         e_rgb = !vis ? 3'b000 : (force_out ? 3'b111 : mem[model_addr(h, v)]);
         e_hs = !(h >= HV + HF && h < HV + HF + HSW);
         e_vs = !(v >= VV + VF && v < VV + VF + VSW);
         e_vb = (v >= VV);
      end
      e_fs = (t % 2 == 0) && (a > 0) && (a % FRAME == 0);
      chk("rgb", {r, g, b}, e_rgb);
      chk("hsync", hs, e_hs);
      chk("vsync", vs, e_vs);
      chk("vblank", vb, e_vb);
      chk("fstart", fs, e_fs);

      h2 = a % HT;
      v2 = (a / HT) % VT;
      if (h2 < HV && v2 < VV) chk("addr", addr, model_addr(h2, v2));
      if (h2 == 8 && v2 == 8) chk("addr_8_8", addr, 81);

      if (hs === 1'b0) hs_low_len++;
      else if (hs_low_len > 0) begin
         chk("hs_width", hs_low_len, 2 * HSW);
         hs_low_len = 0;
      end
      if (vs === 1'b0) vs_low_len++;
      else if (vs_low_len > 0) begin
         chk("vs_width", vs_low_len, 2 * VSW * HT);
         vs_low_len = 0;
      end
      if (fs === 1'b1) begin
         if (fs_seen) chk("fs_period", t - last_fs, 2 * FRAME);
         last_fs = t;
         fs_seen = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         t = 0; hs_low_len = 0; vs_low_len = 0; fs_seen = 0;
      end else begin
         t++;
      end
      if (t % 2 == 1) force_smp = force7;
      else force_out = force_smp;
      @(negedge clk);
      check();
   endtask

   initial begin
      bit hit;
      for (int i = 0; i < 8192; i++) mem[i] = 3'($urandom_range(0, 7));

      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      repeat (4 * FRAME + 100) tick();

      force7 = 1'b1;
      repeat (2 * FRAME) tick();
      force7 = 1'b0;
      repeat (4) tick();

      hit = 0;
      for (int n = 0; n < 2 * FRAME + 10; n++) begin
         if (((t / 2) % HT) == HV + HF + 6 && ((t / 2) / HT) % VT == 10 && hs === 1'b0) begin
            hit = 1;
            break;
         end
         tick();
      end
      chk("reach_midline", hit, 1'b1);

      rst = 1'b1;
      tick();
      chk("rst_hs_release", hs, 1'b1);
      chk("rst_addr_zero", addr, 0);
      rst = 1'b0;
      repeat (2 * HT * 3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
